alu_bist_checker: RTL and testbench
===================================

// Module: alu_bist_checker
// PURPOSE
//  Response side of the ALU self-test path. The stimulus side drives identical operands, carry
//  and opcode into two ALU instances (behavioural "A" and synthesised "B").
//  This block consumes both result channels ({W, Zero, Neg}) and compares them cycle by cycle.
//  It counts mismatches and captures the first failure. It also compacts channel A into an
//  18-bit MISR signature. Sits beside the two ALUs inside the BIST wrapper.
// PARAMETERS
//  WIDTH      16        ALU data width; response word RESP_W = WIDTH+2 = {neg, zero, w}
//  CNT_W      16        width of vector length, index and mismatch counters
//  MISR_POLY  18'h00801 Galois feedback taps (x^18 + x^11 + 1)
//  MISR_SEED  18'h00001 signature value loaded on start
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      asynchronous active-low reset
//  start           in   1      begin a run (honoured in IDLE or DONE only)
//  abort           in   1      return to IDLE from any state; has priority over start
//  num_vectors     in   CNT_W  vectors in this run; sampled on start
//  in_valid        in   1      both channels carry a valid result this cycle
//  w_a / w_b       in   WIDTH  ALU results, channel A / channel B
//  zero_a / zero_b in   1      zero flags
//  neg_a / neg_b   in   1      negative flags
//  busy            out  1      high in RUN
//  done            out  1      high in DONE (level, not pulse)
//  pass            out  1      valid when done: mismatch_cnt == 0
//  mismatch_cnt    out  CNT_W  saturating count of mismatching vectors
//  first_fail_idx  out  CNT_W  index (0-based) of first mismatch
//  first_fail_wa   out  WIDTH  w_a at first mismatch
//  first_fail_wb   out  WIDTH  w_b at first mismatch
//  signature       out  18     MISR state over channel A
// BEHAVIOUR
//  - Reset: state IDLE; every output and internal register is 0, signature included.
//  - FSM IDLE -> RUN on start with num_vectors != 0. IDLE -> DONE on start with num_vectors == 0.
//    RUN -> DONE when the accepted vector has idx == N-1. DONE -> RUN/DONE on start, same rules as IDLE.
//    Any state -> IDLE on abort. Start is ignored in RUN.
//  - On an honoured start: N <- num_vectors, idx <- 0, mismatch_cnt <- 0,
//    first_fail_* <- 0, signature <- MISR_SEED, pass <- 0.
//  - RUN, in_valid=1: vector accepted. mismatch = ({neg_a,zero_a,w_a} != {neg_b,zero_b,w_b}).
//    * If mismatch and mismatch_cnt == 0: capture idx, w_a and w_b into first_fail_*.
//    * If mismatch: mismatch_cnt increments, saturating at all-ones.
//    * sig <= {sig[16:0],1'b0} ^ (sig[17] ? MISR_POLY : 0) ^ {neg_a,zero_a,w_a}.
//    * idx increments.
//    * in_valid=0: nothing changes.
//  - All outputs are registered. Updates from vector k are visible the cycle after it is accepted.
//    done/pass rise the cycle after the last vector. pass = (mismatch_cnt == 0) including the last vector.
//  - The 16-bit idx compare handles N = 16'hFFFF without wrap. Inputs are never buffered, and the
//    checker is always ready, so there is no backpressure.
//  - Reset or abort mid-run discards the partial run. Results hold in DONE until the next start or abort.
// STRUCTURE
//  - Package alu_bist_pkg:
//    * WIDTH, RESP_W, MISR_POLY, MISR_SEED
//    * state enum {IDLE, RUN, DONE}
//    * typedef resp_t = struct {neg, zero, w}
//  - One sub-module, alu_misr: 18-bit Galois MISR with clear/load-seed/enable. The FSM, counters
//    and capture logic stay in the top level.
// TESTING
//  1. N=4, both channels w=16'h0000 zero=1 neg=0 each cycle -> done, pass=1, mismatch_cnt=0,
//     signature=18'h31813.
//  2. N=6, w_b differs from w_a on idx 2 (16'h1234 vs 16'h1235) and idx 4 ->
//     mismatch_cnt=2, first_fail_idx=2, first_fail_wa=16'h1234, first_fail_wb=16'h1235, pass=0.
//  3. Flag-only mismatch: idx 0, zero_a=1 zero_b=0, w equal -> mismatch_cnt=1, first_fail_idx=0.
//  4. start with num_vectors=0 -> done=1 and pass=1 the next cycle, signature=18'h00001.
//  5. N=3 with in_valid gapped 1,0,0,1,0,1 -> done only after the 3rd valid.
//     start pulsed mid-RUN -> ignored.
//  6. abort in RUN at idx 1, and rst_n low mid-run -> IDLE, busy=0, done=0.
//     After reset all outputs are 0. A subsequent start with N=2 runs cleanly.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST response checker.
// Response word layout is {neg, zero, w}; the MISR compacts it as-is.
package alu_bist_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned RESP_W = WIDTH + 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MISR_W = 18;

  localparam logic [MISR_W-1:0] MISR_POLY = 18'h00801;
  localparam logic [MISR_W-1:0] MISR_SEED = 18'h00001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             neg;
    logic             zero;
    logic [WIDTH-1:0] w;
  } resp_t;

endpackage

// File: rtl/alu_bist_misr.sv
// 18-bit Galois MISR folding one response word per enabled cycle.
// Priority: clear over load-seed over enable.
module alu_misr
  import alu_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              enable,
  input  logic [RESP_W-1:0] data,
  output logic [MISR_W-1:0] signature
);

  logic [MISR_W-1:0] sigShift;
  logic [MISR_W-1:0] sigNext;

  // Shift left, fold the bit that falls off back into the tap positions.
  always_comb begin
    sigShift = {signature[MISR_W-2:0], 1'b0};
    sigNext  = sigShift ^ (signature[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (load) begin
      signature <= MISR_SEED;
    end else if (enable) begin
      signature <= sigNext;
    end
  end

endmodule

// File: rtl/alu_bist_checker.sv
// Compares the A/B ALU result channels vector by vector, counts mismatches,
// captures the first failure and signs channel A through the MISR.
module alu_bist_checker
  import alu_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_vectors,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  w_a,
  input  logic [WIDTH-1:0]  w_b,
  input  logic              zero_a,
  input  logic              zero_b,
  input  logic              neg_a,
  input  logic              neg_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [WIDTH-1:0]  first_fail_wa,
  output logic [WIDTH-1:0]  first_fail_wb,
  output logic [MISR_W-1:0] signature
);

  state_t           state;
  logic [CNT_W-1:0] vecN;
  logic [CNT_W-1:0] idx;

  resp_t            respA;
  resp_t            respB;
  logic             mismatch;
  logic             lastVec;
  logic             accept;
  logic             startOk;
  logic [CNT_W-1:0] cntNext;

  always_comb begin
    respA    = '{neg: neg_a, zero: zero_a, w: w_a};
    respB    = '{neg: neg_b, zero: zero_b, w: w_b};
    mismatch = (respA != respB);
    // Equality against N-1 never needs idx to pass N, so N = all-ones cannot wrap.
    lastVec  = (idx == vecN - CNT_W'(1));
    accept   = (state == RUN) && in_valid && !abort;
    startOk  = start && !abort && (state != RUN);
    cntNext  = mismatch_cnt;
    if (mismatch && (mismatch_cnt != '1)) begin
      cntNext = mismatch_cnt + CNT_W'(1);
    end
  end

  alu_misr u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (abort),
    .load      (startOk),
    .enable    (accept),
    .data      (respA),
    .signature (signature)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vecN           <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_wa  <= '0;
      first_fail_wb  <= '0;
    end else if (abort) begin
      // Abort discards the partial run entirely.
      state          <= IDLE;
      vecN           <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_wa  <= '0;
      first_fail_wb  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vecN           <= num_vectors;
            idx            <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_wa  <= '0;
            first_fail_wb  <= '0;
            if (num_vectors == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            if (mismatch && (mismatch_cnt == '0)) begin
              first_fail_idx <= idx;
              first_fail_wa  <= w_a;
              first_fail_wb  <= w_b;
            end
            mismatch_cnt <= cntNext;
            idx          <= idx + CNT_W'(1);
            if (lastVec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cntNext == '0);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_checker.sv
// Directed bench for alu_bist_checker: a run-level reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_alu_bist_checker;
  import alu_bist_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_vectors;
  logic              in_valid;
  logic [WIDTH-1:0]  w_a, w_b;
  logic              zero_a, zero_b, neg_a, neg_b;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  mismatch_cnt, first_fail_idx;
  logic [WIDTH-1:0]  first_fail_wa, first_fail_wb;
  logic [MISR_W-1:0] signature;

  int nChecks = 0;
  int nFails  = 0;

  alu_bist_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .num_vectors    (num_vectors),
    .in_valid       (in_valid),
    .w_a            (w_a),
    .w_b            (w_b),
    .zero_a         (zero_a),
    .zero_b         (zero_b),
    .neg_a          (neg_a),
    .neg_b          (neg_b),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_wa  (first_fail_wa),
    .first_fail_wb  (first_fail_wb),
    .signature      (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run-level bookkeeping in plain integers.
  function automatic logic [17:0] misrRef(input logic [17:0] s, input logic [17:0] d);
    logic [17:0] t;
    t = s << 1;
    if (s[17]) t = t ^ 18'h00801;
    return t ^ d;
  endfunction

  bit          mBusy, mDone, mPass, mKnown;
  int          mN, mIdx, mCnt, mFfIdx, mFfWa, mFfWb;
  logic [17:0] mSig;
  bit          tMis;
  int          tCnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy <= 0; mDone <= 0; mPass <= 0; mKnown <= 1;
      mN <= 0; mIdx <= 0; mCnt <= 0; mFfIdx <= 0; mFfWa <= 0; mFfWb <= 0;
      mSig <= '0;
    end else if (abort) begin
      mBusy <= 0; mDone <= 0; mKnown <= 0;
    end else if (start && !mBusy) begin
      mN <= int'(num_vectors); mIdx <= 0; mCnt <= 0;
      mFfIdx <= 0; mFfWa <= 0; mFfWb <= 0; mSig <= 18'h00001; mKnown <= 1;
      mBusy <= (num_vectors != 0);
      mDone <= (num_vectors == 0);
      mPass <= (num_vectors == 0);
    end else if (mBusy && in_valid) begin
      tMis = ({neg_a, zero_a, w_a} != {neg_b, zero_b, w_b});
      tCnt = (tMis && mCnt < 65535) ? mCnt + 1 : mCnt;
      if (tMis && mCnt == 0) begin
        mFfIdx <= mIdx; mFfWa <= int'(w_a); mFfWb <= int'(w_b);
      end
      mCnt <= tCnt;
      mSig <= misrRef(mSig, {neg_a, zero_a, w_a});
      mIdx <= mIdx + 1;
      if (mIdx == mN - 1) begin
        mBusy <= 0; mDone <= 1; mPass <= (tCnt == 0);
      end
    end
  end

  // Per-cycle compare; result fields are undefined after an abort until the next start.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(mBusy));
    chk("done", 32'(done), 32'(mDone));
    if (mKnown) begin
      chk("pass", 32'(pass), 32'(mPass));
      chk("mismatch_cnt", 32'(mismatch_cnt), 32'(mCnt));
      chk("first_fail_idx", 32'(first_fail_idx), 32'(mFfIdx));
      chk("first_fail_wa", 32'(first_fail_wa), 32'(mFfWa));
      chk("first_fail_wb", 32'(first_fail_wb), 32'(mFfWb));
      chk("signature", 32'(signature), 32'(mSig));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doStart(input int n);
    start = 1'b1;
    num_vectors = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic sendVec(input logic v, input logic [15:0] wa, input logic za, input logic na,
                         input logic [15:0] wb, input logic zb, input logic nb);
    in_valid = v;
    w_a = wa; zero_a = za; neg_a = na;
    w_b = wb; zero_b = zb; neg_b = nb;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
    chk({tag, "_ffidx"}, 32'(first_fail_idx), 32'd0);
    chk({tag, "_ffwa"}, 32'(first_fail_wa), 32'd0);
    chk({tag, "_ffwb"}, 32'(first_fail_wb), 32'd0);
    chk({tag, "_sig"}, 32'(signature), 32'd0);
  endtask

  initial begin
    logic [15:0] wv;
    logic [15:0] wbv;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; num_vectors = '0; in_valid = 1'b0;
    w_a = '0; w_b = '0; zero_a = 1'b0; zero_b = 1'b0; neg_a = 1'b0; neg_b = 1'b0;
    #1 rst_n = 1'b0;
    #2 checkAllZero("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // 1: four identical all-zero results with zero flag set
    doStart(4);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) sendVec(1, 16'h0000, 1, 0, 16'h0000, 1, 0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_cnt", 32'(mismatch_cnt), 32'd0);
    chk("t1_sig", 32'(signature), 32'h31813);
    tick();

    // 2: data mismatches at idx 2 and 4
    doStart(6);
    for (int i = 0; i < 6; i++) begin
      wv  = 16'h1232 + 16'(i);
      wbv = wv;
      if (i == 2) wbv = wv + 16'h0001;
      if (i == 4) wbv = wv ^ 16'h0100;
      sendVec(1, wv, 0, 0, wbv, 0, 0);
    end
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_cnt", 32'(mismatch_cnt), 32'd2);
    chk("t2_ffidx", 32'(first_fail_idx), 32'd2);
    chk("t2_ffwa", 32'(first_fail_wa), 32'h1234);
    chk("t2_ffwb", 32'(first_fail_wb), 32'h1235);
    chk("t2_pass", 32'(pass), 32'd0);

    // 3: flag-only mismatch at idx 0
    doStart(2);
    sendVec(1, 16'h0055, 1, 0, 16'h0055, 0, 0);
    sendVec(1, 16'h8001, 0, 1, 16'h8001, 0, 1);
    chk("t3_cnt", 32'(mismatch_cnt), 32'd1);
    chk("t3_ffidx", 32'(first_fail_idx), 32'd0);
    chk("t3_ffwa", 32'(first_fail_wa), 32'h0055);
    chk("t3_pass", 32'(pass), 32'd0);

    // 4: zero-length run
    doStart(0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_sig", 32'(signature), 32'h00001);

    // 5: gapped valid and a start pulse during RUN
    doStart(3);
    sendVec(1, 16'h00A0, 0, 0, 16'h00A0, 0, 0);
    sendVec(0, 16'hDEAD, 0, 0, 16'hBEEF, 1, 1);
    start = 1'b1; num_vectors = 16'd7;
    sendVec(0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    start = 1'b0;
    sendVec(1, 16'hFFFF, 0, 1, 16'hFFFF, 0, 1);
    sendVec(0, 16'h0000, 0, 0, 16'h0001, 0, 0);
    chk("t5_not_done", 32'(done), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    sendVec(1, 16'h7FFF, 0, 0, 16'h7FFF, 0, 0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_pass", 32'(pass), 32'd1);

    // 6a: abort at idx 1, then a clean run
    doStart(5);
    sendVec(1, 16'h0011, 0, 0, 16'h0012, 0, 0);
    abort = 1'b1;
    sendVec(1, 16'h0022, 0, 0, 16'h0022, 0, 0);
    abort = 1'b0;
    chk("t6_abort_busy", 32'(busy), 32'd0);
    chk("t6_abort_done", 32'(done), 32'd0);
    tick();
    doStart(2);
    sendVec(1, 16'h0101, 0, 0, 16'h0101, 0, 0);
    sendVec(1, 16'h0202, 0, 0, 16'h0202, 0, 0);
    waitDone("t6_done_timeout", 4);
    chk("t6_pass", 32'(pass), 32'd1);

    // 6b: reset mid-run, then a clean run
    doStart(4);
    sendVec(1, 16'h0303, 0, 0, 16'h0304, 0, 0);
    sendVec(1, 16'h0404, 0, 0, 16'h0404, 0, 0);
    rst_n = 1'b0;
    #1 checkAllZero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    doStart(2);
    sendVec(1, 16'h1111, 0, 0, 16'h1111, 0, 0);
    sendVec(1, 16'h2222, 0, 0, 16'h2222, 0, 0);
    waitDone("t6b_done_timeout", 4);
    chk("t6b_pass", 32'(pass), 32'd1);
    chk("t6b_cnt", 32'(mismatch_cnt), 32'd0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
